// File: rtl/alu_cmd_issuer.sv
// Queues tagged ALU commands and drives a registered 64-bit ALU, one command in flight.
// Latency: accept -> response is 3 cycles from idle. cmd_ready drops when the FIFO is full; rsp_* hold until rsp_ready.
module alu_cmd_issuer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [3:0]               cmd_op,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_t;

  state_t            state, next_state;
  logic [WIDTH-1:0]  a_mem   [DEPTH];
  logic [WIDTH-1:0]  b_mem   [DEPTH];
  logic [3:0]        op_mem  [DEPTH];
  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic [TAG_W-1:0]  tag_q;
  logic              push, pop;

  // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign cmd_ready = (count_q != FULL);
  assign count     = count_q;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE) || (count_q != '0);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: next_state = WAIT;
      WAIT:  next_state = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (count_q != '0) begin
            pop        = 1'b1;
            next_state = SETUP;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]   <= cmd_a;
      b_mem[wr_ptr]   <= cmd_b;
      op_mem[wr_ptr]  <= cmd_op;
      tag_mem[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      tag_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        alu_a  <= a_mem[rd_ptr];
        alu_b  <= b_mem[rd_ptr];
        alu_op <= op_mem[rd_ptr];
        tag_q  <= tag_mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // The ALU result is only meaningful one cycle after it sampled the operands.
      if (state == WAIT) begin
        rsp_result <= alu_result;
        rsp_tag    <= tag_q;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural registered ALU (op 0 = add, else 0).
module tb_alu_cmd_issuer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_a = '0;
  logic [63:0] cmd_b = '0;
  logic [3:0]  cmd_op = '0;
  logic [3:0]  cmd_tag = '0;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [2:0]  count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    alu_result <= (alu_op == 4'h0) ? alu_a + alu_b : 64'h0;

  alu_cmd_issuer #(.WIDTH(64), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag),
    .count(count), .busy(busy)
  );

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  // Issues one command from idle with rsp_ready=1; returns cycles from acceptance to rsp_valid.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                       input logic [3:0] tag, output int lat, output logic [63:0] res,
                       output logic [3:0] t);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = rsp_result;
    t   = rsp_tag;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (alu_a !== 64'h0) begin n_fail++; $display("FAIL reset_alu_a: got %h expected 0", alu_a); end
    n_checks++; if (alu_b !== 64'h0) begin n_fail++; $display("FAIL reset_alu_b: got %h expected 0", alu_b); end
    n_checks++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL reset_alu_op: got %h expected 0", alu_op); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (rsp_result !== 64'h0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
    n_checks++; if (rsp_tag !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_tag: got %h expected 0", rsp_tag); end
  endtask

  task automatic test_single_add();
    int lat; logic [63:0] res; logic [3:0] t;
    wait_idle();
    issue(64'd5, 64'd7, 4'h0, 4'h3, lat, res, t);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL single_latency: got %0d cycles expected 3", lat); end
    n_checks++; if (res !== 64'd12) begin n_fail++; $display("FAIL single_result: got %0d expected 12", res); end
    n_checks++; if (t !== 4'h3) begin n_fail++; $display("FAIL single_tag: got %0d expected 3", t); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_clear: got %b expected 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    n_checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7) begin n_fail++; $display("FAIL single_alu_hold: got a=%0d b=%0d expected 5 7", alu_a, alu_b); end
  endtask

  task automatic test_wrap();
    int lat; logic [63:0] res; logic [3:0] t;
    wait_idle();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h0, 4'h1, lat, res, t);
    n_checks++; if (res !== 64'h0) begin n_fail++; $display("FAIL wrap_result: got %h expected 0", res); end
    n_checks++; if (t !== 4'h1) begin n_fail++; $display("FAIL wrap_tag: got %0d expected 1", t); end
  endtask

  task automatic test_other_op();
    int lat; logic [63:0] res; logic [3:0] t;
    wait_idle();
    issue(64'd9, 64'd9, 4'h5, 4'h7, lat, res, t);
    n_checks++; if (res !== 64'h0) begin n_fail++; $display("FAIL op5_result: got %0d expected 0", res); end
    n_checks++; if (t !== 4'h7) begin n_fail++; $display("FAIL op5_tag: got %0d expected 7", t); end
    n_checks++; if (alu_op !== 4'h5) begin n_fail++; $display("FAIL op5_alu_op: got %h expected 5", alu_op); end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    int idx = 0;
    int got = 0;
    int c = 0;
    bit acc;
    bit acc5 = 1'b0;
    bit unstable = 1'b0;
    logic [63:0] r0;
    logic [3:0]  t0;
    logic [63:0] res_q[$];
    logic [3:0]  tag_q[$];
    wait_idle();
    rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (idx < 6) begin
        cmd_valid = 1'b1; cmd_a = 64'(idx); cmd_b = 64'd100; cmd_op = 4'h0; cmd_tag = 4'(idx);
      end
      acc = cmd_ready;
      @(posedge clk); #1;
      if (acc && idx < 6) begin accepted++; idx++; end
    end
    n_checks++; if (accepted !== 5) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 5", accepted); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready: got %b expected 0", cmd_ready); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", count); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd100 || rsp_tag !== 4'h0) begin
      n_fail++; $display("FAIL bp_head_rsp: got v=%b r=%0d t=%0d expected 1 100 0", rsp_valid, rsp_result, rsp_tag);
    end
    r0 = rsp_result; t0 = rsp_tag;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_result !== r0 || rsp_tag !== t0 || count !== 3'd4) unstable = 1'b1;
    end
    n_checks++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL bp_stall_stable: got unstable=%b expected 0", unstable); end
    rsp_ready = 1'b1;
    while (got < 6 && c < 60) begin
      if (rsp_valid === 1'b1) begin
        res_q.push_back(rsp_result); tag_q.push_back(rsp_tag); got++;
      end
      acc = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      c++;
      if (acc) begin acc5 = 1'b1; cmd_valid = 1'b0; end
    end
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL bp_rsp_count: got %0d expected 6", got); end
    n_checks++; if (acc5 !== 1'b1) begin n_fail++; $display("FAIL bp_tag5_accept: got %b expected 1", acc5); end
    for (int i = 0; i < got; i++) begin
      n_checks++; if (res_q[i] !== 64'(100 + i)) begin n_fail++; $display("FAIL bp_result[%0d]: got %0d expected %0d", i, res_q[i], 100 + i); end
      n_checks++; if (tag_q[i] !== 4'(i)) begin n_fail++; $display("FAIL bp_tag[%0d]: got %0d expected %0d", i, tag_q[i], i); end
    end
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    wait_idle();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 64'd1; cmd_b = 64'd1; cmd_op = 4'h0;
    cmd_tag = 4'h8; @(posedge clk); #1;
    cmd_tag = 4'h9; @(posedge clk); #1;
    cmd_tag = 4'hA; @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++; if (count !== 3'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got count=%0d busy=%b expected 2 1", count, busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: busy=%b expected 0", busy); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_cmd_ready: got %b expected 1", cmd_ready); end
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) spurious++;
    end
    n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL rst_mid_no_rsp: got %0d spurious cycles expected 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_wrap();
    test_other_op();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
